// File: rtl/dlx_alu_mc_if.sv
// Handshake and operand/result bundle for the multi-cycle DLX ALU.
// The producer/consumer side uses the master modport, and the ALU uses the slave modport.
interface dlx_alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [5:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             div_by_zero;

    modport master (
        output in_valid, a, b, alu_op, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, alu_op, out_ready,
        output in_ready, out_valid, result, result_hi, zero, div_by_zero
    );
endinterface

// File: rtl/dlx_alu_mc.sv
// Multi-cycle DLX execute unit: single-cycle ALU ops plus iterative shift-add multiply
// and restoring divide on operand magnitudes, with registered results behind valid/ready.
module dlx_alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic         clk,
    input logic         rst_n,
    dlx_alu_mc_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state, state_nx;

    // p_hi/p_lo hold the running product (hi:lo), or the remainder and the quotient shift register.
    logic [WIDTH-1:0] p_hi, p_lo, opd;
    logic [SHW-1:0]   cnt;
    logic             neg_q, neg_r;

    logic [WIDTH-1:0] res_q, hi_q;
    logic             zero_q, dbz_q;

    logic             ld, dbz_d;
    logic [WIDTH-1:0] res_d, hi_d, sc_res;

    logic [5:0]   op;
    logic [SHW-1:0] sh;
    logic         is_mul, is_div, sgn, b_zero, a_neg, b_neg, last;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op     = bus.alu_op;
    assign sh     = bus.b[SHW-1:0];
    assign is_mul = (op == 6'h30) || (op == 6'h31);
    assign is_div = (op == 6'h32) || (op == 6'h33);
    assign sgn    = ~op[0];
    assign b_zero = (bus.b == '0);
    assign a_neg  = sgn & bus.a[WIDTH-1];
    assign b_neg  = sgn & bus.b[WIDTH-1];
    assign a_mag  = a_neg ? -bus.a : bus.a;
    assign b_mag  = b_neg ? -bus.b : bus.b;
    assign last   = (cnt == SHW'(WIDTH-1));

    always_comb begin
        sc_res = '0;
        case (op)
            6'h00: sc_res = bus.a;
            6'h08: sc_res = bus.a + bus.b;
            6'h0a: sc_res = bus.a - bus.b;
            6'h0c: sc_res = bus.a & bus.b;
            6'h0d: sc_res = bus.a | bus.b;
            6'h0e: sc_res = bus.a ^ bus.b;
            6'h14: sc_res = bus.a << sh;
            6'h16: sc_res = bus.a >> sh;
            6'h17: sc_res = $signed(bus.a) >>> sh;
            6'h18: sc_res = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
            6'h19: sc_res = {{(WIDTH-1){1'b0}}, bus.a != bus.b};
            6'h1a: sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) <  $signed(bus.b)};
            6'h1c: sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) <= $signed(bus.b)};
            6'h3a: sc_res = {{(WIDTH-1){1'b0}}, bus.a <  bus.b};
            6'h3c: sc_res = {{(WIDTH-1){1'b0}}, bus.a <= bus.b};
            default: sc_res = '0;
        endcase
    end

    // One shift-add step: add multiplicand on the multiplier LSB, then shift the pair right.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;
    logic [2*WIDTH-1:0] prod;
    assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opd} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], p_lo[WIDTH-1:1]};
    assign prod      = {mul_hi_nx, mul_lo_nx};

    // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi_nx, div_lo_nx;
    assign div_sh    = {p_hi, p_lo[WIDTH-1]};
    assign div_diff  = div_sh - {1'b0, opd};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_hi_nx = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_lo_nx = {p_lo[WIDTH-2:0], div_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        res_d    = '0;
        hi_d     = '0;
        dbz_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (is_mul) begin
                        state_nx = S_MUL;
                    end else if (is_div && !b_zero) begin
                        state_nx = S_DIV;
                    end else begin
                        state_nx = S_DONE;
                        ld       = 1'b1;
                        if (is_div) begin
                            res_d = '1;
                            hi_d  = bus.a;
                            dbz_d = 1'b1;
                        end else begin
                            res_d = sc_res;
                        end
                    end
                end
            end
            S_MUL: begin
                if (last) begin
                    state_nx      = S_DONE;
                    ld            = 1'b1;
                    {hi_d, res_d} = neg_q ? -prod : prod;
                end
            end
            S_DIV: begin
                if (last) begin
                    state_nx = S_DONE;
                    ld       = 1'b1;
                    res_d    = neg_q ? -div_lo_nx : div_lo_nx;
                    hi_d     = neg_r ? -div_hi_nx : div_hi_nx;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_hi  <= '0;
            p_lo  <= '0;
            opd   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && (is_mul || is_div)) begin
                        p_hi  <= '0;
                        p_lo  <= is_mul ? b_mag : a_mag;
                        opd   <= is_mul ? a_mag : b_mag;
                        cnt   <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                    end
                end
                S_MUL: begin
                    p_hi <= mul_hi_nx;
                    p_lo <= mul_lo_nx;
                    cnt  <= cnt + 1'b1;
                end
                S_DIV: begin
                    p_hi <= div_hi_nx;
                    p_lo <= div_lo_nx;
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            hi_q   <= '0;
            zero_q <= 1'b1;
            dbz_q  <= 1'b0;
        end else if (ld) begin
            res_q  <= res_d;
            hi_q   <= hi_d;
            zero_q <= (res_d == '0);
            dbz_q  <= dbz_d;
        end
    end

    assign bus.in_ready    = (state == S_IDLE);
    assign bus.out_valid   = (state == S_DONE);
    assign bus.result      = res_q;
    assign bus.result_hi   = hi_q;
    assign bus.zero        = zero_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_dlx_alu_mc.sv
// Scoreboard bench for dlx_alu_mc: directed corner cases, timing checks and randomized ops
// against an arithmetic reference model.
module tb_dlx_alu_mc;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    dlx_alu_mc_if #(.WIDTH(W)) bus ();

    dlx_alu_mc #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] r;
        logic [31:0] h;
        logic        z;
        logic        d;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        int sh;
        e.op = op; e.r = '0; e.h = '0; e.d = 1'b0;
        sa = $signed(a); sb = $signed(b);
        ua = a; ub = b;
        sh = int'(b % 32);
        case (op)
            6'h00: e.r = a;
            6'h08: e.r = a + b;
            6'h0a: e.r = a - b;
            6'h0c: e.r = a & b;
            6'h0d: e.r = a | b;
            6'h0e: e.r = a ^ b;
            6'h14: e.r = a << sh;
            6'h16: e.r = a >> sh;
            6'h17: e.r = $signed(a) >>> sh;
            6'h18: e.r = {31'b0, a == b};
            6'h19: e.r = {31'b0, a != b};
            6'h1a: e.r = {31'b0, sa < sb};
            6'h1c: e.r = {31'b0, sa <= sb};
            6'h3a: e.r = {31'b0, ua < ub};
            6'h3c: e.r = {31'b0, ua <= ub};
            6'h30: begin p = sa * sb; e.r = p[31:0]; e.h = p[63:32]; end
            6'h31: begin up = ua * ub; e.r = up[31:0]; e.h = up[63:32]; end
            6'h32: begin
                if (b == 0) begin e.r = '1; e.h = a; e.d = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin e.r = a; e.h = '0; end
                else begin p = sa / sb; e.r = p[31:0]; p = sa % sb; e.h = p[31:0]; end
            end
            6'h33: begin
                if (b == 0) begin e.r = '1; e.h = a; e.d = 1'b1; end
                else begin e.r = a / b; e.h = a % b; end
            end
            default: ;
        endcase
        e.z = (e.r == 0);
        return e;
    endfunction

    // Consumer-side monitor: every accepted result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_result: got %h expected none", bus.result);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check($sformatf("op%h result", e.op), bus.result, e.r);
                check($sformatf("op%h result_hi", e.op), bus.result_hi, e.h);
                check($sformatf("op%h zero", e.op), {31'b0, bus.zero}, {31'b0, e.z});
                check($sformatf("op%h div_by_zero", e.op), {31'b0, bus.div_by_zero}, {31'b0, e.d});
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output int acc);
        int k;
        k = 0;
        while (!bus.in_ready && k < 200) begin @(posedge clk); #1; k++; end
        if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1; bus.alu_op = op; bus.a = a; bus.b = b;
        if (push) sbq.push_back(model(op, a, b));
        @(posedge clk); #1;
        acc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int acc, output int lat);
        int k;
        k = 0;
        while (!bus.out_valid && k < 100) begin @(posedge clk); #1; k++; end
        lat = cyc - acc + 1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.out_ready = 1'b1;
        while (sbq.size() > 0 && k < 200) begin @(posedge clk); #1; k++; end
        check("drain_empty", sbq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        check({tag, " out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, " result"}, bus.result, 32'd0);
        check({tag, " result_hi"}, bus.result_hi, 32'd0);
        check({tag, " zero"}, {31'b0, bus.zero}, 32'd1);
        check({tag, " div_by_zero"}, {31'b0, bus.div_by_zero}, 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hffff_ffff;
            3: return 32'h8000_0000;
            4: return 32'h7fff_ffff;
            5: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] ops [0:20] = '{6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h14, 6'h16, 6'h17,
                               6'h18, 6'h19, 6'h1a, 6'h1c, 6'h3a, 6'h3c, 6'h30, 6'h31,
                               6'h32, 6'h33, 6'h3f, 6'h01};

    initial begin
        int acc, lat, k;
        logic [31:0] xa, xb;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.alu_op = '0; bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD overflow wrap: 1-cycle latency, ready again one cycle after the take
        issue(6'h08, 32'h7fff_ffff, 32'h1, 1'b1, acc);
        wait_valid(acc, lat);
        check("add_latency", lat, 1);
        @(posedge clk); #1;
        check("add_in_ready_back", {31'b0, bus.in_ready}, 32'd1);

        issue(6'h17, 32'h8000_0000, 32'd31, 1'b1, acc); drain();
        issue(6'h14, 32'h1, 32'h3f, 1'b1, acc);          drain();
        issue(6'h1a, 32'hffff_ffff, 32'h1, 1'b1, acc);   drain();
        issue(6'h3a, 32'hffff_ffff, 32'h1, 1'b1, acc);   drain();
        issue(6'h00, 32'h0, 32'h5, 1'b1, acc);           drain();
        issue(6'h3f, 32'h1234, 32'h5, 1'b1, acc);        drain();

        issue(6'h30, 32'hffff_fffd, 32'd7, 1'b1, acc);
        wait_valid(acc, lat);
        check("mul_latency", lat, 33);
        drain();
        issue(6'h31, 32'hffff_fffd, 32'd7, 1'b1, acc);   drain();
        issue(6'h32, 32'hffff_fff9, 32'd2, 1'b1, acc);
        wait_valid(acc, lat);
        check("div_latency", lat, 33);
        drain();
        issue(6'h32, 32'h8000_0000, 32'hffff_ffff, 1'b1, acc); drain();
        issue(6'h33, 32'd5, 32'd0, 1'b1, acc);
        wait_valid(acc, lat);
        check("divz_latency", lat, 1);
        drain();

        // Backpressure: result held, unit busy, new requests ignored
        bus.out_ready = 1'b0;
        xa = $urandom; xb = $urandom;
        issue(6'h0e, xa, xb, 1'b1, acc);
        wait_valid(acc, lat);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.alu_op = 6'h08; bus.a = $urandom; bus.b = $urandom;
            @(posedge clk); #1;
            check("bp out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("bp in_ready", {31'b0, bus.in_ready}, 32'd0);
            check("bp result", bus.result, xa ^ xb);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("bp release out_valid", {31'b0, bus.out_valid}, 32'd0);
        drain();

        // Randomized ops with random consumer stalls
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 20)];
            bus.out_ready = ($urandom_range(0, 3) != 0);
            issue(op, pick_operand(), pick_operand(), 1'b1, acc);
            k = 0;
            while (!bus.in_ready && k < 200) begin
                bus.out_ready = ($urandom_range(0, 2) != 0);
                @(posedge clk); #1; k++;
            end
        end
        drain();

        // Asynchronous reset in the middle of a divide
        issue(6'h08, 32'h10, 32'h20, 1'b1, acc); drain();
        issue(6'h32, 32'd1000, 32'd7, 1'b0, acc);
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(6'h08, 32'd40, 32'd2, 1'b1, acc);
        wait_valid(acc, lat);
        check("post_reset_add_latency", lat, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
